// File: rtl/alu_input_sequencer_pkg.sv
// alu_input_sequencer_pkg: step encodings and default debounce length shared by the ALU input loader
package alu_input_sequencer_pkg;
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_DONE = 2'd3} state_t;
  localparam int DB_CYCLES_100MHZ = 1000000;
endpackage

// File: rtl/alu_input_sequencer_button_debouncer.sv
// button_debouncer: 2-FF synchroniser, level debouncer and registered rising-edge pulse for one button
//   i_clock, i_reset_n : clock, async active-low reset
//   i_btn              : raw bouncing button
//   o_level            : debounced level
//   o_rise             : one-cycle pulse when o_level goes 0 -> 1
module button_debouncer #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W = 3
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);
  logic [1:0] sync;
  logic [DB_W-1:0] cnt;
  logic diff, done;
  assign diff = sync[1] ^ o_level;
  // the DB_CYCLES-th consecutive differing cycle accepts the new level
  assign done = diff && cnt == DB_W'(DB_CYCLES - 1);
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      sync    <= '0;
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync    <= {sync[0], i_btn};
      cnt     <= diff && !done ? cnt + 1'b1 : '0;
      o_level <= done ? sync[1] : o_level;
      o_rise  <= done && sync[1];
    end
endmodule

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: LOAD/BACK button stepper capturing switches into ALU operand A, B and opcode
//   i_clock, i_reset_n     : clock, async active-low reset
//   i_sw                   : raw switch bank, sampled on the capture edge
//   i_btn_load, i_btn_back : raw bouncing buttons
//   o_alu_A, o_alu_B       : stored operands
//   o_alu_Op               : stored opcode
//   o_state                : current step for LEDs
//   o_valid                : one-cycle strobe when a new opcode is committed
module alu_input_sequencer
  import alu_input_sequencer_pkg::*;
#(
  parameter int N_SW = 16,
  parameter int N_OPERANDS = 8,
  parameter int N_OP = 6,
  parameter int DB_CYCLES = DB_CYCLES_100MHZ,
  localparam int DB_W = $clog2(DB_CYCLES + 1)
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [N_SW-1:0]       i_sw,
  input  logic                  i_btn_load,
  input  logic                  i_btn_back,
  output logic [N_OPERANDS-1:0] o_alu_A,
  output logic [N_OPERANDS-1:0] o_alu_B,
  output logic [N_OP-1:0]       o_alu_Op,
  output logic [1:0]            o_state,
  output logic                  o_valid
);
  logic load, back, unused_load_level, unused_back_level, unused_sw;
  state_t state;
  button_debouncer #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_load (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_btn(i_btn_load),
    .o_level(unused_load_level), .o_rise(load)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_back (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_btn(i_btn_back),
    .o_level(unused_back_level), .o_rise(back)
  );
  assign unused_sw = ^i_sw;
  assign o_state = state;
  // simultaneous load and back pulses cancel each other
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state    <= S_A;
      o_alu_A  <= '0;
      o_alu_B  <= '0;
      o_alu_Op <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (load && !back) begin
        if (state == S_B) o_alu_B <= i_sw[N_OPERANDS-1:0];
        else if (state == S_OP) o_alu_Op <= i_sw[N_OP-1:0];
        else o_alu_A <= i_sw[N_OPERANDS-1:0];
        o_valid <= state == S_OP;
        state   <= state == S_A ? S_B : state == S_B ? S_OP : state == S_OP ? S_DONE : S_B;
      end else if (back && !load)
        state <= state == S_B ? S_A : state == S_OP ? S_B : state == S_DONE ? S_OP : S_A;
    end
endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb_alu_input_sequencer: scoreboarded random/directed bench for alu_input_sequencer
module tb_alu_input_sequencer;
  logic i_clock = 0, i_reset_n = 0, i_btn_load = 0, i_btn_back = 0;
  logic [15:0] i_sw = '0;
  logic [7:0] o_alu_A, o_alu_B;
  logic [5:0] o_alu_Op;
  logic [1:0] o_state;
  logic o_valid;

  alu_input_sequencer #(.N_SW(16), .N_OPERANDS(8), .N_OP(6), .DB_CYCLES(4)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_sw(i_sw),
    .i_btn_load(i_btn_load), .i_btn_back(i_btn_back),
    .o_alu_A(o_alu_A), .o_alu_B(o_alu_B), .o_alu_Op(o_alu_Op),
    .o_state(o_state), .o_valid(o_valid)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {logic [24:0] v; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, vcnt = 0, vexp = 0;
  int ma = 0, mb = 0, mop = 0, mst = 0;
  logic [24:0] cur, prev = '0;
  assign cur = {o_alu_A, o_alu_B, o_alu_Op, o_state, o_valid};

  always @(posedge i_clock) cyc++;

  // monitor: every visible change (or strobe) must match the next scoreboard entry
  always @(negedge i_clock)
    if (!i_reset_n) prev = cur;
    else if (cur[24:1] != prev[24:1] || cur[0]) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change got=%h at cycle %0d", cur, cyc);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
          n_bad++;
          $display("FAIL event got=%h@%0d expected=%h@%0d", cur, cyc, e.v, e.cyc);
        end
      end
      if (cur[0]) vcnt++;
      prev = cur;
    end

  task automatic chk(input string n, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", n, got, exp);
    end
  endtask

  // reference: effect of one accepted press; c is the cycle the capture is due
  task automatic apply(input bit l, input bit b, input logic [15:0] sw, input int c);
    bit v;
    if (l == b) return;
    v = 0;
    if (b) begin
      if (mst == 0) return;
      mst = mst - 1;
    end else begin
      if (mst == 1) mb = sw & 8'hFF;
      else if (mst == 2) begin mop = sw & 6'h3F; v = 1; vexp++; end
      else ma = sw & 8'hFF;
      mst = (mst == 3) ? 1 : mst + 1;
    end
    q.push_back('{{ma[7:0], mb[7:0], mop[5:0], mst[1:0], v}, c});
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mop = 0; mst = 0;
  endtask

  task automatic drive(input bit l, input bit b, input bit on);
    i_btn_load = l & on;
    i_btn_back = b & on;
  endtask

  // press: optional 2-on/2-off bouncing, then a clean hold, release and idle gap
  task automatic press(input bit l, input bit b, input logic [15:0] sw, input int hold, input int tog);
    @(negedge i_clock);
    i_sw = sw;
    repeat (tog) begin
      drive(l, b, 1); repeat (2) @(negedge i_clock);
      drive(l, b, 0); repeat (2) @(negedge i_clock);
    end
    drive(l, b, 1);
    apply(l, b, sw, cyc + 7);
    repeat (hold) @(negedge i_clock);
    drive(l, b, 0);
    repeat (8) @(negedge i_clock);
  endtask

  task automatic assert_reset();
    @(posedge i_clock);
    #2 i_reset_n = 0;
    #1 chk("async_reset_outputs", int'(cur), 0);
    model_reset();
  endtask

  initial begin
    bit l, b;
    int r;
    repeat (3) @(negedge i_clock);
    chk("reset_state", int'(cur), 0);
    i_reset_n = 1;
    // basic A -> B -> Op sequence
    press(1, 0, 16'h00A5, 10, 0);
    press(1, 0, 16'h003C, 10, 0);
    press(1, 0, 16'h0015, 10, 0);
    // bouncing LOAD then a clean hold: a single capture from S_DONE
    press(1, 0, 16'h0042, 10, 5);
    // BACK navigation
    press(1, 0, 16'h0099, 10, 0);
    press(0, 1, 16'h1234, 10, 0);
    press(0, 1, 16'h1234, 10, 0);
    press(0, 1, 16'h1234, 10, 0);
    press(1, 0, 16'h0011, 10, 0);
    press(1, 0, 16'h0022, 10, 0);
    press(1, 0, 16'h002B, 10, 0);
    press(1, 0, 16'h0077, 10, 0);
    // simultaneous buttons cancel
    press(1, 1, 16'hFFFF, 10, 0);
    // async reset mid-sequence
    assert_reset();
    @(posedge i_clock);
    #2 i_reset_n = 1;
    // reset mid-debounce in S_OP with LOAD released before release
    press(1, 0, 16'h0031, 10, 0);
    press(1, 0, 16'h0032, 10, 0);
    @(negedge i_clock);
    i_sw = 16'h0033;
    i_btn_load = 1;
    repeat (3) @(negedge i_clock);
    assert_reset();
    @(negedge i_clock);
    i_btn_load = 0;
    repeat (3) @(negedge i_clock);
    @(posedge i_clock);
    #2 i_reset_n = 1;
    repeat (15) @(negedge i_clock);
    chk("no_capture_after_reset_state", int'(o_state), 0);
    // same but LOAD held through reset release: one A capture
    press(1, 0, 16'h0041, 10, 0);
    press(1, 0, 16'h0042, 10, 0);
    @(negedge i_clock);
    i_sw = 16'h005A;
    i_btn_load = 1;
    repeat (3) @(negedge i_clock);
    assert_reset();
    repeat (3) @(negedge i_clock);
    @(posedge i_clock);
    #2 i_reset_n = 1;
    apply(1, 0, 16'h005A, cyc + 7);
    repeat (12) @(negedge i_clock);
    i_btn_load = 0;
    repeat (8) @(negedge i_clock);
    // randomized presses
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      l = r < 60 || r >= 85;
      b = r >= 60;
      press(l, b, 16'($urandom), $urandom_range(8, 14), $urandom_range(0, 2));
    end
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge i_clock);
    chk("scoreboard_drained", q.size(), 0);
    chk("valid_pulse_count", vcnt, vexp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
